// File: rtl/tof_frame_analyzer.sv
// tof_frame_analyzer: serial scan of a 64-zone ToF distance frame (one zone per clock),
//    publishing global minimum + zone, per-row minima, valid/near counts and an obstacle flag.
// Latency: edge sampled at clock k, zones at k+1..k+64, results and result_valid pulse at k+65.
// Backpressure: none; a frame edge arriving while busy is dropped and sets sticky overrun.
// Ports: clk, reset (sync, active-high), data_ready (level, rising edge = new frame),
//    distance_mm [63:0][15:0] packed, clear_overrun (pulse) -> min_dist_mm, min_zone,
//    row_min [7:0][15:0] packed, valid_count, near_count, obstacle, result_valid, busy, overrun.
// Optional: define TOF_TEMPORAL_FILTER_EN to add a per-zone IIR filter (alpha = 1/4)
//    whose output replaces the raw distance in all compares.
module tof_frame_analyzer #(
   parameter logic [15:0] NEAR_THRESH_MM = 16'd300,
   parameter logic [15:0] MAX_VALID_MM   = 16'd4000,
   parameter logic [6:0]  OBST_ZONES     = 7'd4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          data_ready,
   input  logic [1023:0] distance_mm,
   input  logic          clear_overrun,
   output logic [15:0]   min_dist_mm,
   output logic [5:0]    min_zone,
   output logic [127:0]  row_min,
   output logic [6:0]    valid_count,
   output logic [6:0]    near_count,
   output logic          obstacle,
   output logic          result_valid,
   output logic          busy,
   output logic          overrun
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCAN    = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic          dr_q, dr_d;
   logic          frame_edge;
   logic [1023:0] frame_q;
   logic          frame_ld;
   logic [5:0]    idx_q, idx_d;

   // scan accumulators
   logic [15:0]       min_acc_q, min_acc_d;
   logic [5:0]        zone_acc_q, zone_acc_d;
   logic [6:0]        vcnt_acc_q, vcnt_acc_d;
   logic [6:0]        ncnt_acc_q, ncnt_acc_d;
   logic [7:0][15:0]  rmin_acc_q, rmin_acc_d;

   // published results
   logic [15:0]       min_dist_q, min_dist_d;
   logic [5:0]        min_zone_q, min_zone_d;
   logic [7:0][15:0]  row_min_q, row_min_d;
   logic [6:0]        valid_count_q, valid_count_d;
   logic [6:0]        near_count_q, near_count_d;
   logic              obstacle_q, obstacle_d;
   logic              result_valid_q, result_valid_d;
   logic              overrun_q, overrun_d;

   logic [15:0] cur_raw;
   logic [15:0] cur_val;
   logic        zone_valid;
   logic [2:0]  row_sel;

   assign cur_raw    = frame_q[{idx_q, 4'b0000} +: 16];
   assign zone_valid = (cur_raw != 16'd0) && (cur_raw <= MAX_VALID_MM);
   assign row_sel    = idx_q[5:3];
   assign frame_edge = data_ready & ~dr_q;

`ifdef TOF_TEMPORAL_FILTER_EN
   logic [15:0]        filt_q [64];
   logic [63:0]        filt_init_q, filt_init_d;
   logic [15:0]        filt_cur;
   logic signed [16:0] filt_diff;
   logic [15:0]        filt_step;
   logic [15:0]        filt_new;
   logic               filt_we;

   always_comb begin
      filt_cur  = filt_q[idx_q];
      filt_diff = $signed({1'b0, cur_raw}) - $signed({1'b0, filt_cur});
      // step lies in [-16384, 16383]; modulo-2^16 add lands between filt and d
      filt_step = 16'(filt_diff >>> 2);
      filt_new  = filt_cur + filt_step;
      // first valid sample of a zone seeds the filter directly
      cur_val   = filt_init_q[idx_q] ? filt_new : cur_raw;
      filt_we   = (state_q == ST_SCAN) && zone_valid;
      filt_init_d = filt_init_q;
      if (filt_we) filt_init_d[idx_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (filt_we) filt_q[idx_q] <= cur_val;
   end

   always_ff @(posedge clk) begin
      if (reset) filt_init_q <= '0;
      else       filt_init_q <= filt_init_d;
   end
`else
   assign cur_val = cur_raw;
`endif

   always_comb begin
      state_d        = state_q;
      dr_d           = data_ready;
      frame_ld       = 1'b0;
      idx_d          = idx_q;
      min_acc_d      = min_acc_q;
      zone_acc_d     = zone_acc_q;
      vcnt_acc_d     = vcnt_acc_q;
      ncnt_acc_d     = ncnt_acc_q;
      rmin_acc_d     = rmin_acc_q;
      min_dist_d     = min_dist_q;
      min_zone_d     = min_zone_q;
      row_min_d      = row_min_q;
      valid_count_d  = valid_count_q;
      near_count_d   = near_count_q;
      obstacle_d     = obstacle_q;
      result_valid_d = 1'b0;
      overrun_d      = overrun_q;

      // set takes priority over clear when both happen in one cycle
      if (clear_overrun) overrun_d = 1'b0;
      if (frame_edge && (state_q != ST_IDLE)) overrun_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (frame_edge) begin
               frame_ld   = 1'b1;
               idx_d      = 6'd0;
               min_acc_d  = 16'hFFFF;
               zone_acc_d = 6'd0;
               vcnt_acc_d = 7'd0;
               ncnt_acc_d = 7'd0;
               rmin_acc_d = {8{16'hFFFF}};
               state_d    = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (zone_valid) begin
               vcnt_acc_d = vcnt_acc_q + 7'd1;
               if (cur_val < NEAR_THRESH_MM) ncnt_acc_d = ncnt_acc_q + 7'd1;
               // strict compare: on ties the lowest zone index is kept
               if (cur_val < min_acc_q) begin
                  min_acc_d  = cur_val;
                  zone_acc_d = idx_q;
               end
               if (cur_val < rmin_acc_q[row_sel]) rmin_acc_d[row_sel] = cur_val;
            end
            if (idx_q == 6'd63) state_d = ST_PUBLISH;
            else                idx_d   = idx_q + 6'd1;
         end
         ST_PUBLISH: begin
            min_dist_d     = min_acc_q;
            min_zone_d     = zone_acc_q;
            row_min_d      = rmin_acc_q;
            valid_count_d  = vcnt_acc_q;
            near_count_d   = ncnt_acc_q;
            obstacle_d     = (ncnt_acc_q >= OBST_ZONES);
            result_valid_d = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         // reset to 1 so a data_ready held high across reset is not a new frame
         dr_q           <= 1'b1;
         idx_q          <= 6'd0;
         min_acc_q      <= 16'hFFFF;
         zone_acc_q     <= 6'd0;
         vcnt_acc_q     <= 7'd0;
         ncnt_acc_q     <= 7'd0;
         rmin_acc_q     <= {8{16'hFFFF}};
         min_dist_q     <= 16'hFFFF;
         min_zone_q     <= 6'd0;
         row_min_q      <= {8{16'hFFFF}};
         valid_count_q  <= 7'd0;
         near_count_q   <= 7'd0;
         obstacle_q     <= 1'b0;
         result_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         dr_q           <= dr_d;
         idx_q          <= idx_d;
         min_acc_q      <= min_acc_d;
         zone_acc_q     <= zone_acc_d;
         vcnt_acc_q     <= vcnt_acc_d;
         ncnt_acc_q     <= ncnt_acc_d;
         rmin_acc_q     <= rmin_acc_d;
         min_dist_q     <= min_dist_d;
         min_zone_q     <= min_zone_d;
         row_min_q      <= row_min_d;
         valid_count_q  <= valid_count_d;
         near_count_q   <= near_count_d;
         obstacle_q     <= obstacle_d;
         result_valid_q <= result_valid_d;
         overrun_q      <= overrun_d;
      end
   end

   // frame buffer is pure datapath; it is only read after being loaded
   always_ff @(posedge clk) begin
      if (frame_ld) frame_q <= distance_mm;
   end

   assign min_dist_mm  = min_dist_q;
   assign min_zone     = min_zone_q;
   assign row_min      = row_min_q;
   assign valid_count  = valid_count_q;
   assign near_count   = near_count_q;
   assign obstacle     = obstacle_q;
   assign result_valid = result_valid_q;
   assign busy         = (state_q != ST_IDLE);
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_tof_frame_analyzer.sv
// Directed testbench for tof_frame_analyzer: frame scans, boundary patterns,
// overrun handling, reset mid-scan and back-to-back frames at minimum spacing.
module tb_tof_frame_analyzer;

   logic          clk = 1'b0;
   logic          reset;
   logic          data_ready;
   logic [1023:0] distance_mm;
   logic          clear_overrun;
   logic [15:0]   min_dist_mm;
   logic [5:0]    min_zone;
   logic [127:0]  row_min;
   logic [6:0]    valid_count;
   logic [6:0]    near_count;
   logic          obstacle;
   logic          result_valid;
   logic          busy;
   logic          overrun;

   int checks = 0;
   int errors = 0;

   tof_frame_analyzer dut (
      .clk          (clk),
      .reset        (reset),
      .data_ready   (data_ready),
      .distance_mm  (distance_mm),
      .clear_overrun(clear_overrun),
      .min_dist_mm  (min_dist_mm),
      .min_zone     (min_zone),
      .row_min      (row_min),
      .valid_count  (valid_count),
      .near_count   (near_count),
      .obstacle     (obstacle),
      .result_valid (result_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [15:0] v);
      for (int z = 0; z < 64; z++) distance_mm[z*16 +: 16] = v;
   endtask

   task automatic set_zone(input int z, input logic [15:0] v);
      distance_mm[z*16 +: 16] = v;
   endtask

   // Raises data_ready, scrambles distance_mm once the edge is sampled, waits
   // (bounded) for result_valid and returns the number of clocks counted from
   // the sampling edge (1) to the result edge; -1 on timeout.
   task automatic run_frame(output int lat);
      lat = -1;
      data_ready = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (c == 1) set_all(16'd1);
         if (result_valid) begin
            lat = c;
            break;
         end
      end
      data_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      data_ready = 1'b1;
      clear_overrun = 1'b0;
      set_all(16'd700);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      checks++; if (min_dist_mm !== 16'hFFFF) begin errors++; $display("FAIL rst_min got %h exp ffff", min_dist_mm); end
      checks++; if (min_zone !== 6'd0) begin errors++; $display("FAIL rst_zone got %0d exp 0", min_zone); end
      checks++; if (row_min !== {8{16'hFFFF}}) begin errors++; $display("FAIL rst_rowmin got %h exp all ffff", row_min); end
      checks++; if ({valid_count, near_count, obstacle, result_valid, overrun} !== 17'd0) begin
         errors++; $display("FAIL rst_flags got v%0d n%0d o%b r%b ov%b exp all 0", valid_count, near_count, obstacle, result_valid, overrun);
      end
      // data_ready was high across reset exit: no scan may start
      repeat (5) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_noscan busy got %b exp 0", busy); end
      data_ready = 1'b0;
      tick();
   endtask

   task automatic test_single_min();
      int lat;
      set_all(16'd1000);
      set_zone(37, 16'd250);
      run_frame(lat);
      checks++; if (lat !== 66) begin errors++; $display("FAIL t1_latency got %0d exp 66", lat); end
      checks++; if (min_dist_mm !== 16'd250) begin errors++; $display("FAIL t1_min got %0d exp 250", min_dist_mm); end
      checks++; if (min_zone !== 6'd37) begin errors++; $display("FAIL t1_zone got %0d exp 37", min_zone); end
      checks++; if (valid_count !== 7'd64 || near_count !== 7'd1) begin
         errors++; $display("FAIL t1_counts got v%0d n%0d exp v64 n1", valid_count, near_count);
      end
      checks++; if (obstacle !== 1'b0) begin errors++; $display("FAIL t1_obst got %b exp 0", obstacle); end
      for (int r = 0; r < 8; r++) begin
         logic [15:0] exp_r;
         exp_r = (r == 4) ? 16'd250 : 16'd1000;
         checks++; if (row_min[r*16 +: 16] !== exp_r) begin
            errors++; $display("FAIL t1_row%0d got %0d exp %0d", r, row_min[r*16 +: 16], exp_r);
         end
      end
      tick();
      checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL t1_pulse rv got %b busy %b exp 0 0", result_valid, busy);
      end
   endtask

   task automatic test_all_invalid();
      int lat;
      set_all(16'd0);
      run_frame(lat);
      checks++; if (lat !== 66) begin errors++; $display("FAIL t2_latency got %0d exp 66", lat); end
      checks++; if (min_dist_mm !== 16'hFFFF || min_zone !== 6'd0) begin
         errors++; $display("FAIL t2_min got %h z%0d exp ffff z0", min_dist_mm, min_zone);
      end
      checks++; if (valid_count !== 7'd0 || near_count !== 7'd0 || obstacle !== 1'b0) begin
         errors++; $display("FAIL t2_counts got v%0d n%0d o%b exp 0 0 0", valid_count, near_count, obstacle);
      end
      checks++; if (row_min !== {8{16'hFFFF}}) begin errors++; $display("FAIL t2_rowmin got %h exp all ffff", row_min); end
      tick();
   endtask

   task automatic test_ties_obstacle();
      int lat;
      set_all(16'd5000);
      set_zone(5, 16'd100);
      set_zone(20, 16'd100);
      set_zone(40, 16'd100);
      set_zone(63, 16'd100);
      run_frame(lat);
      checks++; if (lat !== 66) begin errors++; $display("FAIL t3_latency got %0d exp 66", lat); end
      checks++; if (valid_count !== 7'd4 || near_count !== 7'd4) begin
         errors++; $display("FAIL t3_counts got v%0d n%0d exp v4 n4", valid_count, near_count);
      end
      checks++; if (obstacle !== 1'b1) begin errors++; $display("FAIL t3_obst got %b exp 1", obstacle); end
      checks++; if (min_zone !== 6'd5 || min_dist_mm !== 16'd100) begin
         errors++; $display("FAIL t3_min got %0d z%0d exp 100 z5", min_dist_mm, min_zone);
      end
      checks++; if (row_min[15:0] !== 16'd100) begin errors++; $display("FAIL t3_row0 got %0d exp 100", row_min[15:0]); end
      checks++; if (row_min[31:16] !== 16'hFFFF) begin errors++; $display("FAIL t3_row1 got %h exp ffff", row_min[31:16]); end
      checks++; if (row_min[127:112] !== 16'd100) begin errors++; $display("FAIL t3_row7 got %0d exp 100", row_min[127:112]); end
      tick();
   endtask

   task automatic test_overrun();
      int pulses = 0;
      set_all(16'd1000);
      set_zone(37, 16'd250);
      data_ready = 1'b1;
      for (int c = 1; c <= 150; c++) begin
         tick();
         if (result_valid) pulses++;
         if (c == 3) data_ready = 1'b0;
         if (c == 10) begin
            set_all(16'd50);
            data_ready = 1'b1;
         end
         if (c == 12) begin
            checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL t4_set got %b exp 1", overrun); end
         end
         if (c == 15) data_ready = 1'b0;
         if (c == 20) begin
            data_ready = 1'b1;
            clear_overrun = 1'b1;
         end
         if (c == 21) begin
            clear_overrun = 1'b0;
            checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL t4_setwins got %b exp 1", overrun); end
         end
         if (c == 25) data_ready = 1'b0;
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL t4_pulses got %0d exp 1", pulses); end
      checks++; if (min_dist_mm !== 16'd250 || min_zone !== 6'd37) begin
         errors++; $display("FAIL t4_result got %0d z%0d exp 250 z37", min_dist_mm, min_zone);
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL t4_sticky got %b exp 1", overrun); end
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL t4_clear got %b exp 0", overrun); end
   endtask

   task automatic test_reset_mid_scan();
      int pulses = 0;
      int busy_seen = 0;
      int lat;
      set_all(16'd500);
      data_ready = 1'b1;
      repeat (30) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin
         errors++; $display("FAIL t5_abort busy %b rv %b exp 0 0", busy, result_valid);
      end
      checks++; if (min_dist_mm !== 16'hFFFF || valid_count !== 7'd0 || min_zone !== 6'd0 || row_min !== {8{16'hFFFF}}) begin
         errors++; $display("FAIL t5_outs got %h v%0d z%0d exp ffff v0 z0", min_dist_mm, valid_count, min_zone);
      end
      for (int c = 0; c < 80; c++) begin
         tick();
         if (result_valid) pulses++;
         if (busy) busy_seen++;
      end
      checks++; if (pulses !== 0 || busy_seen !== 0) begin
         errors++; $display("FAIL t5_hold pulses %0d busy_cycles %0d exp 0 0", pulses, busy_seen);
      end
      data_ready = 1'b0;
      tick();
      set_all(16'd500);
      run_frame(lat);
      checks++; if (lat !== 66 || min_dist_mm !== 16'd500) begin
         errors++; $display("FAIL t5_rearm lat %0d min %0d exp 66 500", lat, min_dist_mm);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat = -1;
      set_all(16'd800);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      set_all(16'd600);
      for (int c = 2; c <= 200; c++) begin
         tick();
         if (result_valid) begin
            lat = c;
            break;
         end
      end
      checks++; if (lat !== 66 || min_dist_mm !== 16'd800) begin
         errors++; $display("FAIL t6_first lat %0d min %0d exp 66 800", lat, min_dist_mm);
      end
      // next edge sampled exactly 66 clocks after the previous one
      run_frame(lat);
      checks++; if (lat !== 66 || min_dist_mm !== 16'd600 || overrun !== 1'b0) begin
         errors++; $display("FAIL t6_second lat %0d min %0d ov %b exp 66 600 0", lat, min_dist_mm, overrun);
      end
      tick();
   endtask

`ifdef TOF_TEMPORAL_FILTER_EN
   task automatic test_filter();
      int lat;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      data_ready = 1'b0;
      tick();
      set_all(16'd1000);
      run_frame(lat);
      checks++; if (min_dist_mm !== 16'd1000) begin errors++; $display("FAIL t7_seed got %0d exp 1000", min_dist_mm); end
      tick();
      set_all(16'd2000);
      run_frame(lat);
      checks++; if (min_dist_mm !== 16'd1250) begin errors++; $display("FAIL t7_filt got %0d exp 1250", min_dist_mm); end
      tick();
   endtask
`endif

   initial begin
      reset = 1'b1;
      data_ready = 1'b0;
      clear_overrun = 1'b0;
      distance_mm = '0;
      test_reset();
      test_single_min();
      test_all_invalid();
      test_ties_obstacle();
      test_overrun();
      test_reset_mid_scan();
      test_back_to_back();
`ifdef TOF_TEMPORAL_FILTER_EN
      test_filter();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
